hps_reset_ctrl: RTL and testbench

HPS_RESET_CTRL -- requirements
Module: hps_reset_ctrl

---
 rtl/hps_reset_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hps_reset_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hps_reset_ctrl.sv
// HPS-to-FPGA reset sequencer: synchronizes the HPS reset, staggers per-channel
// reset release, and handles HPS pending-reset drain and FPGA-initiated warm reset.
module hps_reset_ctrl #(
   parameter int CHANNELS    = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGGER     = 4,
   parameter int WARM_PULSE  = 8,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_pending_rst_req_n,
   input  logic [CHANNELS-1:0] i_quiesced,
   input  logic                i_warm_req,
   output logic [CHANNELS-1:0] o_rst_n,
   output logic                o_ready,
   output logic                o_pending_rst_ack_n,
   output logic                o_warm_rst_req_n,
   output logic                o_timeout
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SW = $clog2(STAGGER + 1);
   localparam int PW = $clog2(WARM_PULSE + 1);
   localparam int DW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [2:0] {
      ST_RESET    = 3'd0,
      ST_HOLD     = 3'd1,
      ST_RELEASE  = 3'd2,
      ST_RUN      = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_WARM     = 3'd5,
      ST_WAIT_RST = 3'd6
   } state_t;

   logic [1:0]    rst_sync_r;
   logic          rst_int_n_s;
   logic [1:0]    pend_sync_r;
   logic          pend_n_s;
   state_t        state_r;
   logic [HW-1:0] hold_cnt_r;
   logic [SW-1:0] stag_cnt_r;
   logic [CW-1:0] ch_idx_r;
   logic [PW-1:0] pulse_cnt_r;
   logic [DW-1:0] drain_cnt_r;

   // Reset synchronizer: asserts asynchronously, releases on the second edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_int_n_s = rst_sync_r[1];

   // Pending-reset request synchronizer, idles high.
   always_ff @(posedge i_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         pend_sync_r <= 2'b11;
      end else begin
         pend_sync_r <= {pend_sync_r[0], i_pending_rst_req_n};
      end
   end

   assign pend_n_s = pend_sync_r[1];

   // Sequencer FSM with registered outputs.
   always_ff @(posedge i_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         state_r             <= ST_RESET;
         hold_cnt_r          <= '0;
         stag_cnt_r          <= '0;
         ch_idx_r            <= '0;
         pulse_cnt_r         <= '0;
         drain_cnt_r         <= '0;
         o_rst_n             <= '0;
         o_ready             <= 1'b0;
         o_pending_rst_ack_n <= 1'b1;
         o_warm_rst_req_n    <= 1'b1;
         o_timeout           <= 1'b0;
      end else begin
         case (state_r)
            // RESET is the first hold cycle, so a one-cycle hold releases immediately.
            ST_RESET, ST_HOLD: begin
               if (hold_cnt_r == HW'(HOLD_CYCLES - 1)) begin
                  o_rst_n[0] <= 1'b1;
                  stag_cnt_r <= SW'(1);
                  ch_idx_r   <= CW'(1);
                  if (CHANNELS == 1) begin
                     state_r <= ST_RUN;
                     o_ready <= 1'b1;
                  end else begin
                     state_r <= ST_RELEASE;
                  end
               end else begin
                  state_r    <= ST_HOLD;
                  hold_cnt_r <= hold_cnt_r + HW'(1);
               end
            end
            ST_RELEASE: begin
               if (stag_cnt_r == SW'(STAGGER)) begin
                  o_rst_n[ch_idx_r] <= 1'b1;
                  stag_cnt_r        <= SW'(1);
                  if (ch_idx_r == CW'(CHANNELS - 1)) begin
                     state_r <= ST_RUN;
                     o_ready <= 1'b1;
                  end else begin
                     ch_idx_r <= ch_idx_r + CW'(1);
                  end
               end else begin
                  stag_cnt_r <= stag_cnt_r + SW'(1);
               end
            end
            ST_RUN: begin
               if (!pend_n_s) begin
                  state_r     <= ST_DRAIN;
                  o_ready     <= 1'b0;
                  drain_cnt_r <= '0;
               end else if (i_warm_req) begin
                  state_r     <= ST_WARM;
                  o_ready     <= 1'b0;
                  pulse_cnt_r <= '0;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            // Withdrawn request wins; full quiescence beats a same-cycle timeout.
            ST_DRAIN: begin
               if (pend_n_s) begin
                  state_r     <= ST_RUN;
                  o_ready     <= 1'b1;
                  drain_cnt_r <= '0;
               end else if (&i_quiesced) begin
                  state_r             <= ST_WAIT_RST;
                  o_pending_rst_ack_n <= 1'b0;
                  o_rst_n             <= '0;
                  o_timeout           <= 1'b0;
               end else if (drain_cnt_r == DW'(ACK_TIMEOUT - 1)) begin
                  state_r             <= ST_WAIT_RST;
                  o_pending_rst_ack_n <= 1'b0;
                  o_rst_n             <= '0;
                  o_timeout           <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r + DW'(1);
               end
            end
            ST_WARM: begin
               if (pulse_cnt_r == PW'(0)) begin
                  o_warm_rst_req_n <= 1'b0;
                  pulse_cnt_r      <= PW'(1);
               end else if (pulse_cnt_r == PW'(WARM_PULSE)) begin
                  o_warm_rst_req_n <= 1'b1;
                  state_r          <= ST_WAIT_RST;
               end else begin
                  pulse_cnt_r <= pulse_cnt_r + PW'(1);
               end
            end
            ST_WAIT_RST: begin
               state_r <= ST_WAIT_RST;
            end
            default: begin
               state_r <= ST_RESET;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hps_reset_ctrl.sv
// Scoreboard bench for hps_reset_ctrl: stimulus queues expected output vectors
// tagged with a cycle index; a negedge monitor pops and compares them.
module tb_hps_reset_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pend_n = 1'b1;
   logic [1:0] quiesced = 2'b00;
   logic       warm_req = 1'b0;
   logic [1:0] rst_out;
   logic       ready, ack_n, warm_n, timeout;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [5:0] val;
      string      nm;
   } exp_t;

   exp_t q[$];

   // Vector layout: {o_rst_n[1:0], o_ready, o_pending_rst_ack_n, o_warm_rst_req_n, o_timeout}
   localparam logic [5:0] RSTV  = 6'b00_0_1_1_0;
   localparam logic [5:0] RUNV  = 6'b11_1_1_1_0;
   localparam logic [5:0] BUSYV = 6'b11_0_1_1_0;
   localparam logic [5:0] ACKV  = 6'b00_0_0_1_0;
   localparam logic [5:0] TOV   = 6'b00_0_0_1_1;
   localparam logic [5:0] WLOWV = 6'b11_0_1_0_0;

   hps_reset_ctrl dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_pending_rst_req_n (pend_n),
      .i_quiesced          (quiesced),
      .i_warm_req          (warm_req),
      .o_rst_n             (rst_out),
      .o_ready             (ready),
      .o_pending_rst_ack_n (ack_n),
      .o_warm_rst_req_n    (warm_n),
      .o_timeout           (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle.
   initial begin
      exp_t e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         act = {rst_out, ready, ack_n, warm_n, timeout};
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
               failures++;
               $display("FAIL %s cyc=%0d due=%0d actual=%b required=%b", e.nm, cyc, e.cyc, act, e.val);
            end
         end
      end
   end

   task automatic expect_at(input int c, input logic [5:0] v, input string nm);
      exp_t e;
      e.cyc = c;
      e.val = v;
      e.nm  = nm;
      q.push_back(e);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Assert reset mid-cycle, release it, and check the full release sequence.
   task automatic reset_seq(input string tag);
      int base;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      expect_at(cyc, RSTV, {tag, "_async_rst"});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      expect_at(base + 1,  RSTV,          {tag, "_edge1"});
      expect_at(base + 17, RSTV,          {tag, "_edge17"});
      expect_at(base + 18, 6'b01_0_1_1_0, {tag, "_edge18_ch0"});
      expect_at(base + 21, 6'b01_0_1_1_0, {tag, "_edge21"});
      expect_at(base + 22, RUNV,          {tag, "_edge22_ready"});
      wait_to(base + 22);
      checks++;
      if ({rst_out, ready, ack_n, warm_n, timeout} !== RUNV) begin
         failures++;
         $display("FAIL %s_direct_run actual=%b required=%b", tag,
                  {rst_out, ready, ack_n, warm_n, timeout}, RUNV);
      end
   endtask

   initial begin
      int t;
      exp_t e;

      reset_seq("por");

      // Drain completed by quiescence.
      t = cyc;
      pend_n = 1'b0;
      quiesced = 2'b01;
      expect_at(t + 2,  RUNV,  "drain_pre");
      expect_at(t + 3,  BUSYV, "drain_enter");
      expect_at(t + 12, BUSYV, "drain_wait");
      expect_at(t + 13, ACKV,  "drain_ack");
      expect_at(t + 20, ACKV,  "wait_rst_hold");
      wait_to(t + 12);
      quiesced = 2'b11;
      wait_to(t + 21);
      pend_n = 1'b1;
      quiesced = 2'b00;

      reset_seq("rst2");

      // Withdrawn pending request returns to RUN.
      t = cyc;
      pend_n = 1'b0;
      quiesced = 2'b01;
      expect_at(t + 3, BUSYV, "abort_enter");
      expect_at(t + 7, BUSYV, "abort_wait");
      expect_at(t + 8, RUNV,  "abort_run");
      wait_to(t + 5);
      pend_n = 1'b1;
      wait_to(t + 10);

      // Drain forced by timeout after 1024 cycles.
      t = cyc;
      pend_n = 1'b0;
      quiesced = 2'b00;
      expect_at(t + 3,    BUSYV, "to_enter");
      expect_at(t + 1026, BUSYV, "to_before");
      expect_at(t + 1027, TOV,   "to_forced_ack");
      expect_at(t + 1030, TOV,   "to_sticky");
      wait_to(t + 1031);
      checks++;
      if ({rst_out, ready, ack_n, warm_n, timeout} !== TOV) begin
         failures++;
         $display("FAIL to_direct actual=%b required=%b",
                  {rst_out, ready, ack_n, warm_n, timeout}, TOV);
      end
      pend_n = 1'b1;

      reset_seq("rst3");

      // One-cycle warm request gives an 8-cycle pulse.
      t = cyc;
      warm_req = 1'b1;
      expect_at(t + 1,  BUSYV, "warm_enter");
      expect_at(t + 2,  WLOWV, "warm_low_first");
      expect_at(t + 9,  WLOWV, "warm_low_last");
      expect_at(t + 10, BUSYV, "warm_end");
      expect_at(t + 12, BUSYV, "warm_wait_rst");
      wait_to(t + 1);
      warm_req = 1'b0;
      wait_to(t + 13);
      checks++;
      if ({rst_out, ready, ack_n, warm_n, timeout} !== BUSYV) begin
         failures++;
         $display("FAIL warm_direct actual=%b required=%b",
                  {rst_out, ready, ack_n, warm_n, timeout}, BUSYV);
      end

      reset_seq("rst4");

      // Pending and warm together: drain wins, warm ignored while draining.
      t = cyc;
      pend_n = 1'b0;
      expect_at(t + 2, RUNV,  "both_pre");
      expect_at(t + 3, BUSYV, "both_drain");
      expect_at(t + 5, BUSYV, "both_no_warm");
      expect_at(t + 6, ACKV,  "both_ack");
      wait_to(t + 2);
      warm_req = 1'b1;
      wait_to(t + 5);
      warm_req = 1'b0;
      quiesced = 2'b11;
      wait_to(t + 7);
      pend_n = 1'b1;
      quiesced = 2'b00;

      reset_seq("rst5");

      // Reset asserted during the warm pulse.
      t = cyc;
      warm_req = 1'b1;
      expect_at(t + 4, WLOWV, "midwarm_low");
      wait_to(t + 1);
      warm_req = 1'b0;
      wait_to(t + 4);
      reset_seq("midwarm");

      // Reset asserted during drain.
      t = cyc;
      pend_n = 1'b0;
      quiesced = 2'b01;
      expect_at(t + 3, BUSYV, "middrain_enter");
      wait_to(t + 4);
      pend_n = 1'b1;
      quiesced = 2'b00;
      reset_seq("middrain");

      repeat (4) @(negedge clk);
      @(posedge clk);
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         failures++;
         $display("FAIL %s never compared due=%0d", e.nm, e.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
